// File: rtl/sser_wr_shifter.sv
// Write-side serial shifter: bus writes load a frame bit-by-bit, SEND serializes it MSB-first.
// Outputs are registered; busy covers exactly FRAME_BITS*2*CLK_DIV cycles per frame.
module sser_wr_shifter #(
  parameter int FRAME_BITS = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sser_n,
  input  logic                            ba13,
  input  logic                            ba12,
  input  logic [3:0]                      ba7_4,
  input  logic                            br_w,
  output logic                            sd_clk,
  output logic                            sd_out,
  output logic                            sd_oe,
  output logic                            busy,
  output logic                            ovr,
  output logic [$clog2(FRAME_BITS+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
  localparam logic [3:0] CMD_ABORT = 4'b1000;
  localparam logic [3:0] CMD_SEND  = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI} state_t;

  state_t                state_q;
  logic                  win_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [CW-1:0]         tx_left_q;
  logic [PW-1:0]         phase_q;
  logic                  sd_clk_q, sd_out_q, sd_oe_q, busy_q, ovr_q;

  logic win, acc, is_shift, is_send, is_abort, last_phase;

  // One access per bus write cycle: only the first clock of the window counts.
  assign win        = ~sser_n & ~ba13 & ba12 & ~br_w;
  assign acc        = win & ~win_q;
  assign is_shift   = acc & (ba7_4[3:1] == 3'b001);
  assign is_send    = acc & (ba7_4 == CMD_SEND);
  assign is_abort   = acc & (ba7_4 == CMD_ABORT);
  assign last_phase = (phase_q == PW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      tx_left_q <= '0;
      phase_q   <= '0;
      sd_clk_q  <= 1'b0;
      sd_out_q  <= 1'b0;
      sd_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      win_q <= win;
      case (state_q)
        IDLE: begin
          if (is_abort) begin
            frame_q   <= '0;
            bit_cnt_q <= '0;
            ovr_q     <= 1'b0;
          end else if (is_shift) begin
            if (bit_cnt_q == FULL) begin
              ovr_q <= 1'b1;
            end else begin
              frame_q   <= {frame_q[FRAME_BITS-2:0], ba7_4[0]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (is_send) begin
            if (bit_cnt_q != FULL) begin
              ovr_q <= 1'b1;
            end else begin
              state_q   <= SHIFT_LO;
              busy_q    <= 1'b1;
              sd_oe_q   <= 1'b1;
              sd_out_q  <= frame_q[FRAME_BITS-1];
              sd_clk_q  <= 1'b0;
              phase_q   <= '0;
              tx_left_q <= FULL;
            end
          end
        end
        default: begin
          if (is_abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            sd_oe_q   <= 1'b0;
            sd_clk_q  <= 1'b0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            ovr_q     <= 1'b0;
          end else begin
            if (is_shift || is_send) ovr_q <= 1'b1;
            if (!last_phase) begin
              phase_q <= phase_q + 1'b1;
            end else begin
              phase_q <= '0;
              if (state_q == SHIFT_LO) begin
                state_q  <= SHIFT_HI;
                sd_clk_q <= 1'b1;
              end else if (tx_left_q > CW'(1)) begin
                // Next bit goes out on the falling sd_clk edge.
                frame_q   <= frame_q << 1;
                sd_out_q  <= frame_q[FRAME_BITS-2];
                sd_clk_q  <= 1'b0;
                tx_left_q <= tx_left_q - 1'b1;
                state_q   <= SHIFT_LO;
              end else begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                sd_oe_q   <= 1'b0;
                sd_clk_q  <= 1'b0;
                bit_cnt_q <= '0;
                frame_q   <= '0;
              end
            end
          end
        end
      endcase
    end
  end

  assign sd_clk  = sd_clk_q;
  assign sd_out  = sd_out_q;
  assign sd_oe   = sd_oe_q;
  assign busy    = busy_q;
  assign ovr     = ovr_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_sser_wr_shifter.sv
// Bench for sser_wr_shifter: vector table, corner-case sequences and random traffic vs a cycle model.
module tb_sser_wr_shifter;
  localparam int N = 8;
  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sser_n, ba13, ba12, br_w;
  logic [3:0] ba7_4;
  logic       sd_clk, sd_out, sd_oe, busy, ovr;
  logic [3:0] bit_cnt;

  sser_wr_shifter #(.FRAME_BITS(N), .CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
    .ba7_4(ba7_4), .br_w(br_w), .sd_clk(sd_clk), .sd_out(sd_out),
    .sd_oe(sd_oe), .busy(busy), .ovr(ovr), .bit_cnt(bit_cnt)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference: loaded bits as a number, transmission as elapsed cycles m_k since SEND.
  bit          m_prev_win;
  int          m_nbits;
  logic [15:0] m_fr, m_txfr;
  bit          m_ovr;
  int          m_k;
  bit          m_last;

  int          busy_cycles, rises;
  logic [15:0] cap;
  bit          prev_clk;

  typedef struct {
    logic [3:0] cmd;
    int         len;
    logic       rd;
    int         exp_cnt;
    logic       exp_ovr;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input logic rs, input bit win, input logic [3:0] c);
    bit acc;
    if (!rs) begin
      m_prev_win = 0; m_nbits = 0; m_fr = '0; m_ovr = 0; m_k = -1; m_last = 0;
      return;
    end
    acc = win && !m_prev_win;
    m_prev_win = win;
    if (m_k >= 0) begin
      if (acc && c == 4'h8) begin
        m_k = -1; m_nbits = 0; m_fr = '0; m_ovr = 0;
      end else begin
        if (acc && (c == 4'h2 || c == 4'h3 || c == 4'h9)) m_ovr = 1;
        m_k++;
        if (m_k == N * 2 * D) begin
          m_k = -1; m_nbits = 0; m_fr = '0;
        end
      end
    end else if (acc) begin
      case (c)
        4'h2, 4'h3: begin
          if (m_nbits < N) begin m_fr = {m_fr[14:0], c[0]}; m_nbits++; end
          else m_ovr = 1;
        end
        4'h9: begin
          if (m_nbits == N) begin m_k = 0; m_txfr = m_fr; end
          else m_ovr = 1;
        end
        4'h8: begin m_nbits = 0; m_fr = '0; m_ovr = 0; end
        default: ;
      endcase
    end
    if (m_k >= 0) m_last = m_txfr[N - 1 - m_k / (2 * D)];
  endfunction

  task automatic tick(input logic rs, input logic sn, input logic b13, input logic b12,
                      input logic [3:0] c, input logic bw);
    bit tx;
    rst_n = rs; sser_n = sn; ba13 = b13; ba12 = b12; ba7_4 = c; br_w = bw;
    @(posedge clk);
    model_step(rs, !sn && !b13 && b12 && !bw, c);
    @(negedge clk);
    tx = (m_k >= 0);
    chk("busy", busy, tx);
    chk("sd_oe", sd_oe, tx);
    chk("sd_clk", sd_clk, tx && ((m_k % (2 * D)) >= D));
    chk("sd_out", sd_out, m_last);
    chk("ovr", ovr, m_ovr);
    if (!tx) chk("bit_cnt", bit_cnt, m_nbits);
    if (busy) busy_cycles++;
    if (sd_clk && !prev_clk) begin rises++; cap = {cap[14:0], sd_out}; end
    prev_clk = sd_clk;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] c, input int len, input logic rd);
    repeat (len) tick(1'b1, 1'b0, 1'b0, 1'b1, c, rd);
    idle(1);
  endtask

  task automatic load(input logic [7:0] pat);
    for (int i = 7; i >= 0; i--) wr({3'b001, pat[i]}, 1, 1'b0);
  endtask

  task automatic clear_obs();
    busy_cycles = 0; rises = 0; cap = '0;
  endtask

  initial begin
    vec_t        tbl[14];
    int          w;
    logic [3:0]  c;

    rst_n = 1'b0; sser_n = 1'b1; ba13 = 1'b0; ba12 = 1'b0; ba7_4 = 4'h0; br_w = 1'b0;
    m_k = -1; m_prev_win = 0; m_nbits = 0; m_fr = '0; m_txfr = '0; m_ovr = 0; m_last = 0;
    prev_clk = 0;
    clear_obs();
    @(negedge clk);

    // Reset held with a write window open; the same write then counts once after release.
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
    chk("reset_bit_cnt", bit_cnt, 0);
    chk("reset_outputs", {sd_clk, sd_out, sd_oe, busy, ovr}, 5'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
    idle(1);
    chk("reset_first_write", bit_cnt, 1);

    tbl[0]  = '{4'h8, 1, 1'b0, 0, 1'b0};
    tbl[1]  = '{4'h3, 6, 1'b0, 1, 1'b0};
    tbl[2]  = '{4'h3, 3, 1'b1, 1, 1'b0};
    tbl[3]  = '{4'h5, 1, 1'b0, 1, 1'b0};
    tbl[4]  = '{4'h2, 2, 1'b0, 2, 1'b0};
    tbl[5]  = '{4'h2, 1, 1'b0, 3, 1'b0};
    tbl[6]  = '{4'h3, 1, 1'b0, 4, 1'b0};
    tbl[7]  = '{4'h2, 1, 1'b0, 5, 1'b0};
    tbl[8]  = '{4'h9, 1, 1'b0, 5, 1'b1};
    tbl[9]  = '{4'h8, 1, 1'b0, 0, 1'b0};
    tbl[10] = '{4'hB, 2, 1'b0, 0, 1'b0};
    tbl[11] = '{4'h3, 1, 1'b0, 1, 1'b0};
    tbl[12] = '{4'h2, 1, 1'b0, 2, 1'b0};
    tbl[13] = '{4'h8, 1, 1'b0, 0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      wr(tbl[i].cmd, tbl[i].len, tbl[i].rd);
      chk($sformatf("vec%0d_cnt", i), bit_cnt, tbl[i].exp_cnt);
      chk($sformatf("vec%0d_ovr", i), ovr, tbl[i].exp_ovr);
    end

    // Ninth shift is rejected and must not disturb the loaded frame.
    load(8'hCB);
    chk("full_cnt", bit_cnt, 8);
    wr(4'h2, 1, 1'b0);
    chk("ninth_cnt", bit_cnt, 8);
    chk("ninth_ovr", ovr, 1);
    clear_obs();
    wr(4'h9, 1, 1'b0);
    idle(40);
    chk("ninth_frame_kept", cap[7:0], 8'hCB);

    // Full 0xA5 frame with a rejected SHIFT1 in the middle.
    wr(4'h8, 1, 1'b0);
    load(8'hA5);
    clear_obs();
    wr(4'h9, 1, 1'b0);
    idle(5);
    wr(4'h3, 1, 1'b0);
    chk("busy_shift_ovr", ovr, 1);
    idle(40);
    chk("a5_busy_cycles", busy_cycles, N * 2 * D);
    chk("a5_rises", rises, N);
    chk("a5_bits", cap[7:0], 8'hA5);
    chk("a5_bit_cnt_after", bit_cnt, 0);
    wr(4'h8, 1, 1'b0);
    chk("abort_clears_ovr", ovr, 0);

    // Abort after the third sd_clk rise.
    load(8'h3C);
    clear_obs();
    wr(4'h9, 1, 1'b0);
    w = 0;
    while (rises < 3 && w < 100) begin idle(1); w++; end
    chk("abort_wait_3rd_rise", rises, 3);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0);
    chk("abort_now", {busy, sd_oe, sd_clk}, 3'b000);
    chk("abort_cnt", bit_cnt, 0);
    idle(20);
    chk("abort_no_more_rises", rises, 3);

    // Reset during SHIFT_HI, then a clean frame.
    load(8'h5A);
    wr(4'h9, 1, 1'b0);
    w = 0;
    while (!sd_clk && w < 100) begin idle(1); w++; end
    chk("rst_wait_hi", sd_clk, 1);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    chk("midrst_outputs", {sd_clk, sd_out, sd_oe, busy, ovr}, 5'b0);
    chk("midrst_cnt", bit_cnt, 0);
    load(8'h96);
    clear_obs();
    wr(4'h9, 1, 1'b0);
    idle(40);
    chk("post_rst_bits", cap[7:0], 8'h96);
    chk("post_rst_rises", rises, N);

    // Random bus traffic checked cycle-by-cycle against the model.
    for (int i = 0; i < 400; i++) begin
      w = $urandom_range(0, 99);
      if (w < 45)      c = {3'b001, 1'($urandom_range(0, 1))};
      else if (w < 65) c = 4'h9;
      else if (w < 70) c = 4'h8;
      else             c = 4'($urandom_range(0, 15));
      wr(c, $urandom_range(1, 4), ($urandom_range(0, 9) == 0));
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) tick(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0);
      if ($urandom_range(0, 149) == 0) tick(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/sser_wr_shifter.md
Name: sser_wr_shifter

Overview:
Write-side companion to the serial-read sequencer in the same decode window (SSER low, BA13=0, BA12=1).
- Each qualified bus write conveys one command through address bits BA7..BA4; the data bus is not used.
- Commands clock bits into a frame register, then serialize the frame MSB-first onto a clock/data pair driving the external serial device.
- Exposes busy and sticky-overrun status to the bus logic.

Parameters:
FRAME_BITS, 8, bits per frame (2..16)
CLK_DIV, 2, clk cycles per sd_clk phase (>=1); one bit period = 2*CLK_DIV cycles

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous reset, active low
sser_n  in  1  serial-port select, active low
ba13  in  1  bus address bit 13
ba12  in  1  bus address bit 12
ba7_4  in  4  bus address bits 7..4, command code
br_w  in  1  bus direction, 1=read 0=write
sd_clk  out  1  serial clock to device
sd_out  out  1  serial data to device
sd_oe  out  1  data driver enable, high only while shifting
busy  out  1  frame transmission in progress
ovr  out  1  sticky command-rejected flag
bit_cnt  out  $clog2(FRAME_BITS+1)  bits loaded so far

Behaviour:
- Reset (rst_n=0 at a clk edge), priority over everything:
  - state=IDLE; frame register, bit_cnt, phase counter cleared.
  - win_d=0; outputs sd_clk, sd_out, sd_oe, busy and ovr all 0.
  - Reset mid-frame aborts immediately; no further sd_clk edges.
- Access detection:
  - win = ~sser_n & ~ba13 & ba12 & ~br_w; win_d = win registered.
  - acc = win & ~win_d: exactly one event per bus write cycle, however many clocks the cycle lasts.
  - Read cycles (br_w=1) never generate acc.
- Commands, decoded on acc from ba7_4:
  - 0010 = SHIFT0, 0011 = SHIFT1, 1000 = ABORT, 1001 = SEND.
  - All other codes are ignored with no side effects.
- IDLE (loading):
  - SHIFT0/SHIFT1 with bit_cnt<FRAME_BITS: frame <= {frame[FRAME_BITS-2:0], bit}; bit_cnt+1.
  - SHIFT0/SHIFT1 with bit_cnt==FRAME_BITS: ignored; ovr<=1.
  - SEND with bit_cnt==FRAME_BITS: go to SHIFT_LO. Next cycle busy=1, sd_oe=1, sd_out=frame MSB, sd_clk=0.
  - SEND with bit_cnt<FRAME_BITS: ignored; ovr<=1.
  - ABORT: frame and bit_cnt <= 0; ovr<=0.
- SHIFT_LO: sd_clk=0 for CLK_DIV cycles, sd_out stable, then go to SHIFT_HI.
- SHIFT_HI:
  - sd_clk=1 for CLK_DIV cycles; the device samples sd_out on the sd_clk rise.
  - At the end of the phase, if bits remain: shift the frame left, present the next bit, return to SHIFT_LO.
  - After the last bit: go to IDLE. On the next cycle busy, sd_oe and sd_clk are 0 and bit_cnt is 0.
  - sd_out holds its last value while sd_oe=0.
- Frame timing: busy high exactly FRAME_BITS*2*CLK_DIV cycles.
- Commands while busy:
  - SHIFTx or SEND: ignored; ovr<=1; the frame continues undisturbed.
  - ABORT: the next cycle is IDLE with sd_clk=0, sd_oe=0, busy=0, bit_cnt=0, ovr=0.
- Same-cycle events: only one acc per cycle is possible. Reset beats acc.
- bit_cnt saturates at FRAME_BITS and never wraps.

Test Plan:
- Reset: hold rst_n=0 for 2 clks with a write window active -> all outputs 0, bit_cnt=0. The first write after release counts once.
- Frame: FRAME_BITS=8, CLK_DIV=2; write SHIFT1,0,1,0,0,1,0,1 (0xA5), then SEND.
  - busy high 32 cycles.
  - sd_out sequence 1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - 8 sd_clk rises, each 2 cycles after its bit is presented.
  - bit_cnt=0 afterward.
- Long bus cycle: one write cycle holding win=1 for 6 clks with SHIFT1 -> bit_cnt increments by exactly 1.
  - A read cycle with ba7_4=0011 -> no change.
- Overrun cases, each setting ovr=1:
  - SEND after only 5 bits -> no shifting.
  - 9th SHIFT0 -> bit_cnt stays 8, frame unchanged.
  - SHIFT1 during busy -> current frame output is unchanged.
  - ABORT -> ovr=0.
- Mid-frame abort: ABORT after the 3rd sd_clk rise -> next cycle busy=0, sd_oe=0, sd_clk=0, and no further edges.
- Mid-frame reset: rst_n=0 for 1 clk during SHIFT_HI -> next cycle all outputs 0 and bit_cnt=0.
  - A subsequent full 8-bit load and SEND transmits correctly.
